// File: rtl/algo_1r4w_pkg.sv
// Shared types and constants for the 1r4w write-side buffer.
// Holds the FIFO entry type, geometry constants and a popcount helper.
package algo_1r4w_pkg;

  localparam int WIDTH    = 32;
  localparam int BITADDR  = 13;
  localparam int NUMWRPT  = 4;
  localparam int NUMWTPT  = 2;
  localparam int BITFIFO  = 8;
  localparam int FNUMWRDS = 1 << BITFIFO;
  localparam int ECW      = $clog2(NUMWRPT + 1);
  localparam int DCW      = $clog2(NUMWTPT + 1);

  typedef struct packed {
    logic [BITADDR-1:0] adr;
    logic [WIDTH-1:0]   din;
  } wrfifo_ent_t;

  function automatic logic [ECW-1:0] popcount(
    input logic [NUMWRPT-1:0] v
  );
    logic [ECW-1:0] n;
    n = '0;
    for (int i = 0; i < NUMWRPT; i++)
      n = n + ECW'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/algo_1r4w_bpgen.sv
// Backpressure generator: delays the occupancy count and compares it with a threshold.
// Ports: clk, rst_n, flush, cnt (occupancy), thr (threshold), bp (registered backpressure).
module algo_1r4w_bpgen
  import algo_1r4w_pkg::*;
#(
  parameter int BPDELAY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [BITFIFO:0] cnt,
  input  logic [BITFIFO:0] thr,
  output logic             bp
);

  logic [BITFIFO:0] tap;

  // The final bp flop supplies one cycle of delay; extra stages precede it.
  if (BPDELAY == 1) begin : g_direct
    assign tap = cnt;
  end else begin : g_pipe
    logic [BITFIFO:0] pipe [BPDELAY-1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < BPDELAY-1; k++)
          pipe[k] <= '0;
      end else if (flush) begin
        for (int k = 0; k < BPDELAY-1; k++)
          pipe[k] <= '0;
      end else begin
        pipe[0] <= cnt;
        for (int k = 1; k < BPDELAY-1; k++)
          pipe[k] <= pipe[k-1];
      end
    end
    assign tap = pipe[BPDELAY-2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bp <= 1'b0;
    else if (flush)
      bp <= 1'b0;
    else
      bp <= (tap > thr);
  end

endmodule

// File: rtl/algo_1r4w_wrfifo.sv
// Write-side FIFO: packs up to 4 writes/cycle in port order, drains up to 2/cycle oldest-first.
// Ports: client writes in, drain lanes wt_* out, occupancy, sticky overflow, backpressure.
module algo_1r4w_wrfifo
  import algo_1r4w_pkg::*;
#(
  parameter int BPDELAY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ready,
  input  logic [NUMWRPT-1:0]         write,
  input  logic [NUMWRPT*BITADDR-1:0] wr_adr,
  input  logic [NUMWRPT*WIDTH-1:0]   din,
  input  logic [BITFIFO:0]           bp_thr,
  input  logic                       drain_en,
  output logic                       wr_bp_1,
  output logic                       wr_bp_2,
  output logic                       wr_bp_3,
  output logic                       wr_bp_4,
  output logic [NUMWTPT-1:0]         wt_vld,
  output logic [NUMWTPT*BITADDR-1:0] wt_adr,
  output logic [NUMWTPT*WIDTH-1:0]   wt_din,
  output logic [BITFIFO:0]           wrfifo_cnt,
  output logic                       ovf_err
);

  localparam int CW = BITFIFO + 1;

  wrfifo_ent_t        mem [FNUMWRDS];
  logic [BITFIFO-1:0] wptr;
  logic [BITFIFO-1:0] rptr;
  logic [CW-1:0]      cnt;
  logic               ovf;
  logic               bp;

  logic [DCW-1:0]     dcnt;
  logic [CW-1:0]      space;
  logic [ECW-1:0]     ecnt;
  logic [ECW-1:0]     acnt;
  logic [NUMWRPT-1:0] acc;
  logic [ECW-1:0]     off [NUMWRPT];
  logic               drop;

  // Drain only from entries present before this cycle; no flush-cycle drain.
  always_comb begin
    dcnt = '0;
    if (ready && drain_en)
      dcnt = (cnt >= CW'(NUMWTPT)) ? DCW'(NUMWTPT)
                                   : DCW'(cnt);
  end

  // Drained slots are reusable in the same cycle.
  assign space = CW'(FNUMWRDS) - cnt + CW'(dcnt);
  assign ecnt  = popcount(write);

  // Lowest ports claim slots first; the rest are dropped.
  always_comb begin
    acnt = '0;
    acc  = '0;
    for (int i = 0; i < NUMWRPT; i++) begin
      off[i] = acnt;
      if (write[i] && (CW'(acnt) < space)) begin
        acc[i] = 1'b1;
        acnt   = acnt + 1'b1;
      end
    end
  end

  assign drop = (ecnt != acnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else if (!ready) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      wptr <= wptr + BITFIFO'(acnt);
      rptr <= rptr + BITFIFO'(dcnt);
      cnt  <= cnt + CW'(acnt) - CW'(dcnt);
      if (drop)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ready) begin
      for (int i = 0; i < NUMWRPT; i++)
        if (acc[i])
          mem[wptr + BITFIFO'(off[i])] <= '{
            adr: wr_adr[i*BITADDR +: BITADDR],
            din: din[i*WIDTH +: WIDTH]
          };
    end
  end

  for (genvar k = 0; k < NUMWTPT; k++) begin : g_lane
    wrfifo_ent_t ent;
    assign ent = mem[rptr + BITFIFO'(k)];
    assign wt_vld[k] = (DCW'(k) < dcnt);
    assign wt_adr[k*BITADDR +: BITADDR] = ent.adr;
    assign wt_din[k*WIDTH +: WIDTH] = ent.din;
  end

  algo_1r4w_bpgen #(
    .BPDELAY(BPDELAY)
  ) u_bpgen (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(~ready),
    .cnt  (cnt),
    .thr  (bp_thr),
    .bp   (bp)
  );

  assign wr_bp_1    = bp;
  assign wr_bp_2    = bp;
  assign wr_bp_3    = bp;
  assign wr_bp_4    = bp;
  assign wrfifo_cnt = cnt;
  assign ovf_err    = ovf;

endmodule

// File: tb/tb_algo_1r4w_wrfifo.sv
// Scoreboard bench for algo_1r4w_wrfifo.
// Stimulus pushes expected drains; a negedge monitor pops and compares.
module tb_algo_1r4w_wrfifo;
  import algo_1r4w_pkg::*;

  logic                       clk;
  logic                       rst_n;
  logic                       ready;
  logic [NUMWRPT-1:0]         write;
  logic [NUMWRPT*BITADDR-1:0] wr_adr;
  logic [NUMWRPT*WIDTH-1:0]   din;
  logic [BITFIFO:0]           bp_thr;
  logic                       drain_en;
  logic                       wr_bp_1;
  logic                       wr_bp_2;
  logic                       wr_bp_3;
  logic                       wr_bp_4;
  logic [NUMWTPT-1:0]         wt_vld;
  logic [NUMWTPT*BITADDR-1:0] wt_adr;
  logic [NUMWTPT*WIDTH-1:0]   wt_din;
  logic [BITFIFO:0]           wrfifo_cnt;
  logic                       ovf_err;

  algo_1r4w_wrfifo #(.BPDELAY(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ready     (ready),
    .write     (write),
    .wr_adr    (wr_adr),
    .din       (din),
    .bp_thr    (bp_thr),
    .drain_en  (drain_en),
    .wr_bp_1   (wr_bp_1),
    .wr_bp_2   (wr_bp_2),
    .wr_bp_3   (wr_bp_3),
    .wr_bp_4   (wr_bp_4),
    .wt_vld    (wt_vld),
    .wt_adr    (wt_adr),
    .wt_din    (wt_din),
    .wrfifo_cnt(wrfifo_cnt),
    .ovf_err   (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int seq    = 0;
  logic [BITADDR+WIDTH-1:0] exp_q [$];
  logic [BITADDR+WIDTH-1:0] e_ent;
  logic [BITADDR+WIDTH-1:0] g_ent;
  logic [3:0] bp_all;

  assign bp_all = {wr_bp_4, wr_bp_3, wr_bp_2, wr_bp_1};

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive fresh data on every port; push the ones expected to be accepted.
  task automatic put(input logic [3:0] m, input logic [3:0] acc);
    logic [BITADDR-1:0] a;
    logic [WIDTH-1:0]   d;
    write = m;
    for (int i = 0; i < NUMWRPT; i++) begin
      a = BITADDR'(seq);
      d = 32'hD000_0000 | 32'(seq);
      wr_adr[i*BITADDR +: BITADDR] = a;
      din[i*WIDTH +: WIDTH] = d;
      if (acc[i])
        exp_q.push_back({a, d});
      seq++;
    end
  endtask

  task automatic wait_empty(input int maxc);
    int c;
    for (c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (wrfifo_cnt == 0)
        break;
    end
    chk("drain_timeout", int'(c < maxc), 1);
  endtask

  // Monitor: every valid lane must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wt_vld == 2'b10)
        chk("lane_order", int'(wt_vld), 3);
      for (int k = 0; k < NUMWTPT; k++) begin
        if (wt_vld[k]) begin
          if (exp_q.size() == 0) begin
            chk("drain_unexpected", k, -1);
          end else begin
            e_ent = exp_q.pop_front();
            g_ent = {wt_adr[k*BITADDR +: BITADDR],
                     wt_din[k*WIDTH +: WIDTH]};
            checks++;
            if (g_ent !== e_ent) begin
              errors++;
              $display("FAIL drain_data lane%0d: got %h required %h",
                       k, g_ent, e_ent);
            end
          end
        end
      end
    end
  end

  int exp_cnt [8] = '{0, 4, 6, 8, 10, 12, 14, 16};
  int exp_bp  [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
  int exp_vld [8] = '{0, 3, 3, 3, 3, 3, 3, 3};

  initial begin
    rst_n    = 1'b0;
    ready    = 1'b1;
    write    = '0;
    wr_adr   = '0;
    din      = '0;
    bp_thr   = 9'd10;
    drain_en = 1'b1;

    // Reset with all ports writing: nothing visible.
    put(4'hF, 4'hF);
    repeat (3) begin
      @(negedge clk);
      chk("rst_cnt", int'(wrfifo_cnt), 0);
      chk("rst_vld", int'(wt_vld), 0);
      chk("rst_bp", int'(bp_all), 0);
    end
    step();
    rst_n = 1'b1;

    // Four writes per cycle against two drains per cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("grow_cnt%0d", i), int'(wrfifo_cnt), exp_cnt[i]);
      chk($sformatf("grow_vld%0d", i), int'(wt_vld), exp_vld[i]);
      chk($sformatf("grow_bp%0d", i), int'(bp_all),
          exp_bp[i] ? 15 : 0);
      step();
      if (i < 6)
        put(4'hF, 4'hF);
      else
        write = '0;
    end
    wait_empty(20);

    // Same-address collision: drain order follows port index.
    write = 4'hF;
    for (int i = 0; i < NUMWRPT; i++) begin
      wr_adr[i*BITADDR +: BITADDR] = 13'd5;
      din[i*WIDTH +: WIDTH] = 32'(i);
      exp_q.push_back({13'd5, 32'(i)});
    end
    step();
    write = '0;
    @(negedge clk);
    chk("coll_cnt", int'(wrfifo_cnt), 4);
    wait_empty(10);

    // Lone write on port 2 lands at the next slot; makes rptr odd.
    put(4'b0100, 4'b0100);
    step();
    write = '0;
    wait_empty(10);

    // Fill to 255 without draining, then overflow by three.
    drain_en = 1'b0;
    repeat (63) begin
      put(4'hF, 4'hF);
      step();
    end
    put(4'b0111, 4'b0111);
    step();
    write = '0;
    @(negedge clk);
    chk("fill_cnt", int'(wrfifo_cnt), 255);
    chk("fill_ovf", int'(ovf_err), 0);
    put(4'hF, 4'b0001);
    step();
    write = '0;
    @(negedge clk);
    chk("ovf_cnt", int'(wrfifo_cnt), 256);
    chk("ovf_flag", int'(ovf_err), 1);
    chk("ovf_vld", int'(wt_vld), 0);
    drain_en = 1'b1;
    wait_empty(200);
    chk("wrap_q_empty", exp_q.size(), 0);

    // Flush mid-stream at 37 entries.
    drain_en = 1'b0;
    repeat (9) begin
      put(4'hF, 4'hF);
      step();
    end
    put(4'b0001, 4'b0001);
    step();
    write = '0;
    @(negedge clk);
    chk("pre_flush_cnt", int'(wrfifo_cnt), 37);
    chk("pre_flush_bp", int'(bp_all), 15);
    step();
    ready    = 1'b0;
    drain_en = 1'b1;
    put(4'hF, 4'h0);
    @(negedge clk);
    chk("flush_vld_gate", int'(wt_vld), 0);
    step();
    ready = 1'b1;
    write = '0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_cnt", int'(wrfifo_cnt), 0);
    chk("flush_vld", int'(wt_vld), 0);
    chk("flush_bp", int'(bp_all), 0);
    chk("flush_ovf_held", int'(ovf_err), 1);

    // Traffic resumes cleanly after the flush.
    put(4'b0011, 4'b0011);
    step();
    write = '0;
    wait_empty(10);
    chk("post_q_empty", exp_q.size(), 0);
    chk("post_ovf_held", int'(ovf_err), 1);

    // Async reset clears the sticky flag.
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_ovf", int'(ovf_err), 0);
    chk("rst2_cnt", int'(wrfifo_cnt), 0);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
